qam_tx_seq: RTL and testbench
=============================

# qam_tx_seq

Frame sequencer and FIR configuration controller for the 16-QAM transmit path. It loads the shared I/Q pulse-shaping FIR coefficient set and generates the mod-OSR upsample phase and FIR input-valid strobes. It also sequences each frame as preamble, then payload symbols pulled from upstream, then a zero-symbol tail that flushes the filters. It sits between the symbol source and the symmap/upsampler/FIR chain, and replaces the free-running counter in the symbol generator.

## Interface
- OSR, 11, upsample ratio; symbol period in clocks (2..15)
- NTAPS, 33, coefficient words per load
- COEF_W, 12, coefficient width
- PREAMBLE_LEN, 16, preamble symbols per frame (≥1)
- TAIL_LEN, 4, zero-symbol periods after payload (≥1)

- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle frame request
- frame_len  in  16  payload symbols; sampled when start is accepted
- coef_load_req  in  1  one-cycle coefficient reload request
- coef_bank  in  4  bank select; sampled when coef_load_req is accepted
- coef_wr_valid / coef_wr_ready  in/out  1/1  coefficient word handshake
- coef_wr_data  in  COEF_W  coefficient word
- sym_valid / sym_ready  in/out  1/1  payload symbol handshake
- sym_data  in  4  payload symbol
- sym_out  out  4  symbol to the mapper
- sym_gap  out  1  current period is a zero symbol; the upsampler drives 0
- sym_strobe  out  1  first cycle of a symbol period
- phase  out  4  upsample phase, 0..OSR-1
- fir_datai_valid  out  1  FIR input valid; equals sym_strobe
- fir_coefi  out  COEF_W  registered coefficient word to both FIRs
- fir_coefi_valid  out  1  coefficient word strobe
- fir_coef_sel  out  4  held bank select
- fir_coef_on  out  1  a loaded coefficient set is active
- busy  out  1  state is not IDLE
- done  out  1  one-cycle end-of-frame pulse
- underrun  out  1  sticky: payload symbol was not ready at a period boundary

## Operation
- States: IDLE, COEF_LOAD, PREAMBLE, PAYLOAD, FLUSH, DONE.
- IDLE:
  - coef_load_req moves to COEF_LOAD.
  - Otherwise, start moves to PREAMBLE and clears underrun.
  - If both arrive in the same cycle, coef_load_req wins and start is dropped.
- start and coef_load_req are ignored when the state is not IDLE.
- COEF_LOAD:
  - coef_wr_ready=1.
  - Each accepted word is registered to fir_coefi with fir_coefi_valid=1 on the next cycle.
  - After word NTAPS is accepted: fir_coef_on←1, then return to IDLE.
  - Word count and phase are frozen during the load.
- PREAMBLE/PAYLOAD/FLUSH: phase counts 0..OSR-1 and wraps. sym_strobe and fir_datai_valid are high when phase=0.
- PREAMBLE:
  - sym_out alternates 4'h0, 4'hF, starting with 4'h0, for PREAMBLE_LEN periods. sym_gap=0.
  - At the end of the last period, the next state is PAYLOAD if the latched frame_len≠0, otherwise FLUSH.
- PAYLOAD:
  - sym_ready=1 only when phase=OSR-1, both in PAYLOAD and in the last preamble period.
  - Handshake taken: sym_data is loaded into sym_out at the following phase 0, sym_gap=0, and the payload counter increments.
  - No handshake: that period is a gap (sym_gap=1, sym_out holds its value), underrun←1, and the counter does not increment.
  - When the counter reaches frame_len, the next period boundary enters FLUSH. sym_ready is 0 at that boundary.
- FLUSH: TAIL_LEN periods with sym_gap=1, then DONE.
- DONE: done=1 for one cycle, then IDLE. phase→0, sym_gap→1.
- fir_coef_on and fir_coef_sel persist across frames. Only reset clears them.

## Timing
- Reset values:
  - state IDLE; phase 0; sym_out 0; sym_gap 1.
  - sym_strobe, fir_datai_valid, fir_coefi_valid, coef_wr_ready, sym_ready, busy, done, underrun: all 0.
  - fir_coefi 0; fir_coef_sel 0; fir_coef_on 0.
- Reset asserted mid-frame or mid-load aborts immediately. A partial load leaves fir_coef_on=0.
- All outputs are registered except coef_wr_ready and sym_ready, which decode from registered state and phase only.
- start accepted in cycle t: first sym_strobe (phase 0, sym_out 4'h0) appears at t+1.
- Frame length in cycles: (PREAMBLE_LEN + frame_len + gaps + TAIL_LEN)·OSR. done is asserted in the cycle after the last FLUSH cycle.
- A coefficient word accepted in cycle t appears as fir_coefi_valid at t+1. fir_coef_on rises at the cycle after the NTAPS-th word is accepted.

## Structure
- Shared package qam_tx_pkg holds:
  - the state enum;
  - PREAMBLE_SYM_A=4'h0 and PREAMBLE_SYM_B=4'hF;
  - default OSR=11.
- Sub-module qam_phase_ctr: mod-OSR counter with enable, synchronous clear, and a wrap strobe. It is instantiated once.

## Test plan
- Reset, then coef_load_req, then 33 words 1..33 with valid held → fir_coefi_valid pulses 33 times with values 1..33; fir_coef_on=1 after the last word; state returns to IDLE.
- start with frame_len=3 and sym_valid always high, sym_data 5,6,7 → 16 preamble periods alternating 0/F; sym_out 5,6,7 at strobes 17–19; 4 gap periods; done at cycle 1+23·11.
- frame_len=2 with sym_valid low at the first payload boundary → one gap period, underrun=1, both symbols still sent; done 11 cycles later than the no-gap case.
- frame_len=0 → PREAMBLE goes straight to FLUSH; sym_ready is never asserted; done after (16+4)·11 cycles.
- start and coef_load_req in the same IDLE cycle → COEF_LOAD is entered and start is ignored. start during busy → no effect.
- rstn pulsed low mid-PAYLOAD and mid-COEF_LOAD → all outputs return to reset values; fir_coef_on=0; the next start runs a full frame normally.

Source files
------------

// File: rtl/qam_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : qam_tx_pkg
// Purpose  : Shared types and constants for the 16-QAM transmit sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package qam_tx_pkg;

  // Sequencer states; explicit 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COEF_LOAD = 3'd1,
    ST_PREAMBLE  = 3'd2,
    ST_PAYLOAD   = 3'd3,
    ST_FLUSH     = 3'd4,
    ST_DONE      = 3'd5
  } qam_state_e;

  // Preamble alternates between these two symbols, starting with A.
  localparam logic [3:0] PREAMBLE_SYM_A = 4'h0;
  localparam logic [3:0] PREAMBLE_SYM_B = 4'hF;

  // Default upsample ratio (clocks per symbol period).
  localparam int DEFAULT_OSR = 11;

endpackage : qam_tx_pkg
`default_nettype wire

// File: rtl/qam_phase_ctr.sv
`default_nettype none
// ============================================================================
// Module   : qam_phase_ctr
// Purpose  : Mod-OSR upsample phase counter with enable, synchronous clear
//            and a combinational wrap strobe (high on the last phase).
// Revision : 1.0 - initial release
// ============================================================================
module qam_phase_ctr
  import qam_tx_pkg::*;
#(
  parameter int OSR = DEFAULT_OSR,
  parameter int PW  = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en,
  input  logic          clr,
  output logic [PW-1:0] phase,
  output logic          wrap
);

  localparam logic [PW-1:0] C_LAST = PW'(OSR - 1);

  logic [PW-1:0] r_phase;

  assign phase = r_phase;
  assign wrap  = en && (r_phase == C_LAST);

  // Phase register: clear wins, otherwise count 0..OSR-1 while enabled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_phase <= '0;
    end else if (clr) begin
      r_phase <= '0;
    end else if (en) begin
      r_phase <= wrap ? '0 : r_phase + 1'b1;
    end
  end

endmodule : qam_phase_ctr
`default_nettype wire

// File: rtl/qam_tx_seq.sv
`default_nettype none
// ============================================================================
// Module   : qam_tx_seq
// Purpose  : Frame sequencer (preamble / payload / zero tail) and shared
//            I/Q FIR coefficient loader for the 16-QAM transmit path.
// Revision : 1.0 - initial release
// ============================================================================
module qam_tx_seq
  import qam_tx_pkg::*;
#(
  parameter int OSR          = DEFAULT_OSR,
  parameter int NTAPS        = 33,
  parameter int COEF_W       = 12,
  parameter int PREAMBLE_LEN = 16,
  parameter int TAIL_LEN     = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [15:0]       frame_len,
  input  logic              coef_load_req,
  input  logic [3:0]        coef_bank,
  input  logic              coef_wr_valid,
  output logic              coef_wr_ready,
  input  logic [COEF_W-1:0] coef_wr_data,
  input  logic              sym_valid,
  output logic              sym_ready,
  input  logic [3:0]        sym_data,
  output logic [3:0]        sym_out,
  output logic              sym_gap,
  output logic              sym_strobe,
  output logic [3:0]        phase,
  output logic              fir_datai_valid,
  output logic [COEF_W-1:0] fir_coefi,
  output logic              fir_coefi_valid,
  output logic [3:0]        fir_coef_sel,
  output logic              fir_coef_on,
  output logic              busy,
  output logic              done,
  output logic              underrun
);

  localparam int C_WCNT_W = $clog2(NTAPS + 1);

  qam_state_e          r_state;
  qam_state_e          w_state_nxt;
  logic [15:0]         r_frame_len;
  logic [15:0]         r_cnt;        // period index in PREAMBLE/FLUSH, symbols sent in PAYLOAD
  logic [C_WCNT_W-1:0] r_wcnt;
  logic                w_active;
  logic                w_wrap;
  logic                w_load_acc;
  logic                w_start_acc;
  logic                w_coef_acc;
  logic                w_last_coef;
  logic                w_pre_last;
  logic                w_tail_last;
  logic                w_pay_full;
  logic                w_len_nz;
  logic                w_sym_acc;

  assign w_active    = (r_state == ST_PREAMBLE) || (r_state == ST_PAYLOAD) || (r_state == ST_FLUSH);
  assign w_load_acc  = (r_state == ST_IDLE) && coef_load_req;
  assign w_start_acc = (r_state == ST_IDLE) && start && !coef_load_req;
  assign w_pre_last  = (r_cnt == 16'(PREAMBLE_LEN - 1));
  assign w_tail_last = (r_cnt == 16'(TAIL_LEN - 1));
  assign w_pay_full  = (r_cnt == r_frame_len);
  assign w_len_nz    = (r_frame_len != 16'd0);

  assign coef_wr_ready = (r_state == ST_COEF_LOAD);
  assign w_coef_acc    = coef_wr_ready && coef_wr_valid;
  assign w_last_coef   = w_coef_acc && (r_wcnt == C_WCNT_W'(NTAPS - 1));

  // A symbol is requested only on the last phase before a payload period.
  assign sym_ready = w_wrap && (((r_state == ST_PREAMBLE) && w_pre_last && w_len_nz) ||
                                ((r_state == ST_PAYLOAD) && !w_pay_full));
  assign w_sym_acc = sym_ready && sym_valid;

  assign fir_datai_valid = sym_strobe;

  qam_phase_ctr #(
    .OSR (OSR),
    .PW  (4)
  ) u_phase_ctr (
    .clk   (clk),
    .rstn  (rstn),
    .en    (w_active),
    .clr   (!w_active),
    .phase (phase),
    .wrap  (w_wrap)
  );

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; period boundaries are the phase wrap.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (coef_load_req) w_state_nxt = ST_COEF_LOAD;
        else if (start)    w_state_nxt = ST_PREAMBLE;
      end
      ST_COEF_LOAD: if (w_last_coef) w_state_nxt = ST_IDLE;
      ST_PREAMBLE:  if (w_wrap && w_pre_last) w_state_nxt = w_len_nz ? ST_PAYLOAD : ST_FLUSH;
      ST_PAYLOAD:   if (w_wrap && w_pay_full) w_state_nxt = ST_FLUSH;
      ST_FLUSH:     if (w_wrap && w_tail_last) w_state_nxt = ST_DONE;
      ST_DONE:      w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  // Registered outputs, coefficient path and frame counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_frame_len     <= '0;
      r_cnt           <= '0;
      r_wcnt          <= '0;
      sym_out         <= '0;
      sym_gap         <= 1'b1;
      sym_strobe      <= 1'b0;
      fir_coefi       <= '0;
      fir_coefi_valid <= 1'b0;
      fir_coef_sel    <= '0;
      fir_coef_on     <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      underrun        <= 1'b0;
    end else begin
      fir_coefi_valid <= 1'b0;
      sym_strobe      <= 1'b0;
      done            <= 1'b0;
      busy            <= (w_state_nxt != ST_IDLE);

      if (w_load_acc) begin
        fir_coef_sel <= coef_bank;
        r_wcnt       <= '0;
      end
      if (w_coef_acc) begin
        fir_coefi       <= coef_wr_data;
        fir_coefi_valid <= 1'b1;
        r_wcnt          <= r_wcnt + 1'b1;
      end
      if (w_last_coef) fir_coef_on <= 1'b1;

      if (w_start_acc) begin
        r_frame_len <= frame_len;
        r_cnt       <= '0;
        underrun    <= 1'b0;
        sym_out     <= PREAMBLE_SYM_A;
        sym_gap     <= 1'b0;
        sym_strobe  <= 1'b1;
      end

      if (w_wrap) begin
        case (r_state)
          ST_PREAMBLE: begin
            sym_strobe <= 1'b1;
            if (!w_pre_last) begin
              r_cnt   <= r_cnt + 1'b1;
              sym_out <= r_cnt[0] ? PREAMBLE_SYM_A : PREAMBLE_SYM_B;
            end else if (!w_len_nz) begin
              r_cnt   <= '0;
              sym_gap <= 1'b1;
            end else if (w_sym_acc) begin
              r_cnt   <= 16'd1;
              sym_out <= sym_data;
            end else begin
              r_cnt    <= '0;
              sym_gap  <= 1'b1;
              underrun <= 1'b1;
            end
          end
          ST_PAYLOAD: begin
            sym_strobe <= 1'b1;
            if (w_pay_full) begin
              r_cnt   <= '0;
              sym_gap <= 1'b1;
            end else if (w_sym_acc) begin
              r_cnt   <= r_cnt + 1'b1;
              sym_out <= sym_data;
              sym_gap <= 1'b0;
            end else begin
              sym_gap  <= 1'b1;
              underrun <= 1'b1;
            end
          end
          ST_FLUSH: begin
            if (!w_tail_last) begin
              r_cnt      <= r_cnt + 1'b1;
              sym_strobe <= 1'b1;
            end else begin
              done    <= 1'b1;
              sym_gap <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule : qam_tx_seq
`default_nettype wire

// File: tb/tb_qam_tx_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_qam_tx_seq
// Purpose  : Self-checking bench for qam_tx_seq: coefficient loads, frames
//            with and without gaps, empty frames, ignored requests, resets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qam_tx_seq;

  localparam int OSR   = 11;
  localparam int NTAPS = 33;
  localparam int PRE   = 16;
  localparam int TAIL  = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [15:0] frame_len = '0;
  logic        coef_load_req = 1'b0;
  logic [3:0]  coef_bank = '0;
  logic        coef_wr_valid = 1'b0;
  logic        coef_wr_ready;
  logic [11:0] coef_wr_data = '0;
  logic        sym_valid = 1'b0;
  logic        sym_ready;
  logic [3:0]  sym_data = '0;
  logic [3:0]  sym_out;
  logic        sym_gap;
  logic        sym_strobe;
  logic [3:0]  phase;
  logic        fir_datai_valid;
  logic [11:0] fir_coefi;
  logic        fir_coefi_valid;
  logic [3:0]  fir_coef_sel;
  logic        fir_coef_on;
  logic        busy;
  logic        done;
  logic        underrun;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Scoreboards: {sym,gap} per symbol period, and coefficient words.
  logic [4:0]  sym_q[$];
  logic [11:0] coef_q[$];
  logic        mon_en = 1'b1;
  int          sym_seen = 0;
  int          coef_seen = 0;

  // Payload source state.
  logic valid_en = 1'b0;
  int   drop_req = 0;
  int   drop_done = 0;
  int   hs_cnt = 0;
  int   ready_cnt = 0;
  logic hs_prev = 1'b0;

  qam_tx_seq dut (
    .clk             (clk),
    .rstn            (rstn),
    .start           (start),
    .frame_len       (frame_len),
    .coef_load_req   (coef_load_req),
    .coef_bank       (coef_bank),
    .coef_wr_valid   (coef_wr_valid),
    .coef_wr_ready   (coef_wr_ready),
    .coef_wr_data    (coef_wr_data),
    .sym_valid       (sym_valid),
    .sym_ready       (sym_ready),
    .sym_data        (sym_data),
    .sym_out         (sym_out),
    .sym_gap         (sym_gap),
    .sym_strobe      (sym_strobe),
    .phase           (phase),
    .fir_datai_valid (fir_datai_valid),
    .fir_coefi       (fir_coefi),
    .fir_coefi_valid (fir_coefi_valid),
    .fir_coef_sel    (fir_coef_sel),
    .fir_coef_on     (fir_coef_on),
    .busy            (busy),
    .done            (done),
    .underrun        (underrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Symbol source: payload value is a function of the handshake index.
  always @(negedge clk) begin
    logic drop_now;
    if (hs_prev) hs_cnt++;
    sym_data = 4'((hs_cnt + 5) % 16);
    drop_now = sym_ready && (drop_req != drop_done);
    if (drop_now) drop_done++;
    sym_valid = valid_en && !drop_now;
    if (sym_ready) ready_cnt++;
    hs_prev = sym_valid && sym_ready && rstn;
  end

  // Output monitor: pop and compare at every strobe / coefficient pulse.
  always @(negedge clk) begin
    logic [4:0]  e;
    logic [11:0] ce;
    if (rstn && mon_en) begin
      if (sym_strobe) begin
        e = 'x;
        if (sym_q.size() > 0) e = sym_q.pop_front();
        sym_seen++;
        chk("sym_out", 32'(sym_out), 32'(e[4:1]));
        chk("sym_gap", 32'(sym_gap), 32'(e[0]));
        chk("strobe_phase", 32'(phase), 32'd0);
        chk("datai_valid", 32'(fir_datai_valid), 32'd1);
      end
      if (fir_coefi_valid) begin
        ce = 'x;
        if (coef_q.size() > 0) ce = coef_q.pop_front();
        coef_seen++;
        chk("fir_coefi", 32'(fir_coefi), 32'(ce));
      end
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_phase"}, 32'(phase), 32'd0);
    chk({tag, "_sym_out"}, 32'(sym_out), 32'd0);
    chk({tag, "_sym_gap"}, 32'(sym_gap), 32'd1);
    chk({tag, "_strobe"}, 32'(sym_strobe), 32'd0);
    chk({tag, "_datai_valid"}, 32'(fir_datai_valid), 32'd0);
    chk({tag, "_coefi_valid"}, 32'(fir_coefi_valid), 32'd0);
    chk({tag, "_wr_ready"}, 32'(coef_wr_ready), 32'd0);
    chk({tag, "_sym_ready"}, 32'(sym_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_underrun"}, 32'(underrun), 32'd0);
    chk({tag, "_coefi"}, 32'(fir_coefi), 32'd0);
    chk({tag, "_coef_sel"}, 32'(fir_coef_sel), 32'd0);
    chk({tag, "_coef_on"}, 32'(fir_coef_on), 32'd0);
  endtask

  // Full coefficient load; optionally raise start in the request cycle.
  task automatic load_coefs(input logic [3:0] bank, input int first, input logic with_start,
                            input logic on_before);
    int c0;
    c0 = coef_seen;
    coef_load_req = 1'b1;
    coef_bank     = bank;
    start         = with_start;
    frame_len     = 16'd1;
    @(posedge clk); #1;
    coef_load_req = 1'b0;
    start         = 1'b0;
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_wr_ready", 32'(coef_wr_ready), 32'd1);
    coef_wr_valid = 1'b1;
    for (int i = 0; i < NTAPS; i++) begin
      coef_wr_data = 12'(first + i);
      coef_q.push_back(12'(first + i));
      @(posedge clk); #1;
      if (i == NTAPS - 2) chk("coef_on_before_last", 32'(fir_coef_on), 32'(on_before));
      if (i == 10) chk("load_phase_frozen", 32'(phase), 32'd0);
    end
    coef_wr_valid = 1'b0;
    chk("coef_on_after_last", 32'(fir_coef_on), 32'd1);
    chk("load_back_idle", 32'(coef_wr_ready), 32'd0);
    chk("load_busy_end", 32'(busy), 32'd0);
    chk("coef_sel", 32'(fir_coef_sel), 32'(bank));
    @(posedge clk); #1;
    chk("coef_q_drained", 32'(coef_q.size()), 32'd0);
    chk("coef_pulse_count", 32'(coef_seen - c0), 32'(NTAPS));
  endtask

  // One frame: push expected periods, start, wait for done, check timing.
  task automatic run_frame(input int len, input int drops, input int poke);
    int base, r0, s0, c0, dcyc, nper;
    logic found;
    logic [3:0] last;
    base = hs_cnt;
    r0   = ready_cnt;
    s0   = sym_seen;
    last = 4'h0;
    for (int k = 0; k < PRE; k++) begin
      last = (k % 2 == 0) ? 4'h0 : 4'hF;
      sym_q.push_back({last, 1'b0});
    end
    for (int d = 0; d < drops; d++) sym_q.push_back({last, 1'b1});
    for (int i = 0; i < len; i++) begin
      last = 4'((base + i + 5) % 16);
      sym_q.push_back({last, 1'b0});
    end
    for (int k = 0; k < TAIL; k++) sym_q.push_back({last, 1'b1});
    nper = PRE + len + drops + TAIL;

    frame_len = 16'(len);
    drop_req  = drop_req + drops;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c0    = cyc;
    chk("frame_busy", 32'(busy), 32'd1);
    chk("frame_underrun_clr", 32'(underrun), 32'd0);

    found = 1'b0;
    dcyc  = 0;
    for (int i = 1; i <= (nper + 4) * OSR && !found; i++) begin
      @(negedge clk);
      if (poke != 0 && i == poke) begin
        start = 1'b1; coef_load_req = 1'b1; frame_len = 16'd7;
      end
      if (poke != 0 && i == poke + 1) begin
        start = 1'b0; coef_load_req = 1'b0;
      end
      if (done) begin
        found = 1'b1;
        dcyc  = cyc;
      end
    end
    start = 1'b0;
    coef_load_req = 1'b0;
    chk("done_seen", 32'(found), 32'd1);
    chk("done_cycle", 32'(dcyc - c0), 32'(nper * OSR));
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_after_done", 32'(busy), 32'd0);
    chk("sym_q_drained", 32'(sym_q.size()), 32'd0);
    chk("strobe_count", 32'(sym_seen - s0), 32'(nper));
    chk("ready_count", 32'(ready_cnt - r0), 32'(len + drops));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rstn = 1'b1;
    @(posedge clk); #1;
    valid_en = 1'b1;

    // Coefficient load 1..33 into bank 5.
    load_coefs(4'd5, 1, 1'b0, 1'b0);

    // Three payload symbols, source always ready.
    run_frame(3, 0, 0);
    chk("underrun_none", 32'(underrun), 32'd0);

    // Missed first payload handshake: one gap, sticky underrun.
    run_frame(2, 1, 0);
    chk("underrun_set", 32'(underrun), 32'd1);

    // Empty payload: straight to flush, no symbol requests.
    run_frame(0, 0, 0);

    // start and coef_load_req together: load wins, start dropped.
    s0 = sym_seen;
    load_coefs(4'd9, 40, 1'b1, 1'b1);
    repeat (3 * OSR) @(posedge clk);
    #1;
    chk("start_dropped_busy", 32'(busy), 32'd0);
    chk("start_dropped_strobes", 32'(sym_seen - s0), 32'd0);

    // Requests while busy are ignored.
    run_frame(1, 0, 50);
    chk("coef_sel_kept", 32'(fir_coef_sel), 32'd9);
    chk("coef_on_kept", 32'(fir_coef_on), 32'd1);

    // Reset mid-payload.
    mon_en    = 1'b0;
    frame_len = 16'd5;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat ((PRE + 2) * OSR + 4) @(posedge clk);
    #1;
    chk("mid_payload_busy", 32'(busy), 32'd1);
    rstn = 1'b0;
    @(negedge clk);
    chk_reset("rst_payload");
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    // Reset mid coefficient load.
    coef_load_req = 1'b1;
    coef_bank     = 4'd3;
    @(posedge clk); #1;
    coef_load_req = 1'b0;
    coef_wr_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      coef_wr_data = 12'(200 + i);
      @(posedge clk); #1;
    end
    rstn = 1'b0;
    coef_wr_valid = 1'b0;
    @(negedge clk);
    chk_reset("rst_load");
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Normal frame after the aborts.
    run_frame(2, 0, 0);
    chk("coef_on_after_reset", 32'(fir_coef_on), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_qam_tx_seq
`default_nettype wire
